// File: rtl/alu_sequencer_if.sv
// Instruction handshake and ArithmeticUnit bus for alu_sequencer.
// slave is the sequencer side; master is the upstream/ALU side.
interface alu_sequencer_if #(
  parameter int DATA_W  = 4,
  parameter int INSTR_W = 10
);
  logic               instr_valid;
  logic [INSTR_W-1:0] instr;
  logic               instr_ready;
  logic               alu_add;
  logic               alu_sub;
  logic               alu_lshift;
  logic               alu_rshift;
  logic [DATA_W-1:0]  alu_in1;
  logic [DATA_W-1:0]  alu_in2;
  logic [DATA_W-1:0]  alu_out;
  logic               alu_overflow;
  logic               done;
  logic               illegal;
  logic               flag;

  modport slave (
    input  instr_valid, instr, alu_out, alu_overflow,
    output instr_ready, alu_add, alu_sub, alu_lshift,
    output alu_rshift, alu_in1, alu_in2, done, illegal, flag
  );

  modport master (
    output instr_valid, instr, alu_out, alu_overflow,
    input  instr_ready, alu_add, alu_sub, alu_lshift,
    input  alu_rshift, alu_in1, alu_in2, done, illegal, flag
  );
endinterface

// File: rtl/alu_sequencer.sv
// Control stage ahead of the 4-bit ArithmeticUnit: decode, operand read,
// single-cycle op strobe and register-file writeback.
module alu_sequencer #(
  parameter int DATA_W   = 4,
  parameter int NUM_REGS = 4,
  parameter int INSTR_W  = 10
) (
  input  logic              clk,
  input  logic              reset,
  alu_sequencer_if.slave    bus,
  input  logic [1:0]        dbg_sel,
  output logic [DATA_W-1:0] dbg_data
);

  typedef enum logic [1:0] {
    IDLE,
    DECODE,
    ISSUE,
    WB
  } state_t;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_LSH = 3'b010;
  localparam logic [2:0] OP_RSH = 3'b011;
  localparam logic [2:0] OP_LDI = 3'b100;
  localparam logic [2:0] OP_MOV = 3'b101;

  state_t             state;
  state_t             state_nxt;
  logic [INSTR_W-1:0] ir;
  logic [DATA_W-1:0]  regs [NUM_REGS];
  logic [DATA_W-1:0]  in1;
  logic [DATA_W-1:0]  in2;
  logic               flag_q;

  logic [2:0]         op;
  logic [1:0]         rd;
  logic [1:0]         rs1;
  logic [1:0]         rs2;
  logic [DATA_W-1:0]  imm;
  logic               is_alu;
  logic               is_ldi;
  logic               is_mov;
  logic               wr_en;
  logic [DATA_W-1:0]  wr_data;

  assign op     = ir[9:7];
  assign rd     = ir[6:5];
  assign rs1    = ir[4:3];
  assign rs2    = ir[2:1];
  assign imm    = ir[DATA_W-1:0];
  assign is_alu = ~op[2];
  assign is_ldi = (op == OP_LDI);
  assign is_mov = (op == OP_MOV);

  assign bus.alu_in1 = in1;
  assign bus.alu_in2 = in2;
  assign bus.flag    = flag_q;
  assign dbg_data    = regs[dbg_sel];

  always_comb begin
    state_nxt       = state;
    bus.instr_ready = 1'b0;
    bus.alu_add     = 1'b0;
    bus.alu_sub     = 1'b0;
    bus.alu_lshift  = 1'b0;
    bus.alu_rshift  = 1'b0;
    bus.done        = 1'b0;
    bus.illegal     = 1'b0;
    wr_en           = 1'b0;
    wr_data         = '0;
    unique case (state)
      IDLE: begin
        bus.instr_ready = 1'b1;
        if (bus.instr_valid) state_nxt = DECODE;
      end
      DECODE: begin
        unique case (1'b1)
          is_alu:          state_nxt = ISSUE;
          is_ldi | is_mov: state_nxt = WB;
          default: begin
            bus.illegal = 1'b1;
            state_nxt   = IDLE;
          end
        endcase
      end
      ISSUE: begin
        state_nxt = WB;
        unique case (op)
          OP_ADD:  bus.alu_add    = 1'b1;
          OP_SUB:  bus.alu_sub    = 1'b1;
          OP_LSH:  bus.alu_lshift = 1'b1;
          OP_RSH:  bus.alu_rshift = 1'b1;
          default: ;
        endcase
      end
      WB: begin
        bus.done  = 1'b1;
        wr_en     = 1'b1;
        state_nxt = IDLE;
        unique case (1'b1)
          is_alu:  wr_data = bus.alu_out;
          is_ldi:  wr_data = imm;
          default: wr_data = regs[rs1];
        endcase
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      ir     <= '0;
      in1    <= '0;
      in2    <= '0;
      flag_q <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && bus.instr_valid) ir <= bus.instr;
      // operands stay put until the next DECODE so ISSUE sees stable inputs
      if (state == DECODE) begin
        in1 <= regs[rs1];
        in2 <= regs[rs2];
      end
      if (wr_en) regs[rd] <= wr_data;
      if (wr_en && is_alu) flag_q <= bus.alu_overflow;
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer with a registered 4-bit ALU model.
// Each scenario task checks its own results inline.
module tb_alu_sequencer;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] dbg_sel = 2'd0;
  logic [3:0] dbg_data;
  int         errors = 0;
  int         checks = 0;

  alu_sequencer_if bus ();

  alu_sequencer dut (
    .clk     (clk),
    .reset   (reset),
    .bus     (bus),
    .dbg_sel (dbg_sel),
    .dbg_data(dbg_data)
  );

  always #5 clk = ~clk;

  // registered ArithmeticUnit: result valid the cycle after the strobe
  always @(posedge clk) begin
    if (reset) begin
      bus.alu_out      <= 4'h0;
      bus.alu_overflow <= 1'b0;
    end else if (bus.alu_add) begin
      {bus.alu_overflow, bus.alu_out} <= {1'b0, bus.alu_in1} + {1'b0, bus.alu_in2};
    end else if (bus.alu_sub) begin
      {bus.alu_overflow, bus.alu_out} <= {1'b0, bus.alu_in1} - {1'b0, bus.alu_in2};
    end else if (bus.alu_lshift) begin
      {bus.alu_overflow, bus.alu_out} <= {bus.alu_in1, 1'b0};
    end else if (bus.alu_rshift) begin
      {bus.alu_out, bus.alu_overflow} <= {1'b0, bus.alu_in1};
    end
  end

  function automatic logic [9:0] rr(input logic [2:0] op, input logic [1:0] rd,
                                    input logic [1:0] rs1, input logic [1:0] rs2);
    return {op, rd, rs1, rs2, 1'b0};
  endfunction

  function automatic logic [9:0] ldi(input logic [1:0] rd, input logic [3:0] imm);
    return {3'b100, rd, 1'b0, imm};
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic rd_reg(input logic [1:0] s, output logic [3:0] v);
    dbg_sel = s;
    #1;
    v = dbg_data;
  endtask

  // Sends one instruction and follows it to retirement (or drop).
  // lat = k when done is seen in cycle E+k, -1 if never.
  task automatic exec(input logic [9:0] i, output int lat,
                      output logic [3:0] mask, output int scnt, output logic ill);
    int n;
    lat  = -1;
    mask = 4'h0;
    scnt = 0;
    ill  = 1'b0;
    bus.instr_valid = 1'b1;
    bus.instr       = i;
    n = 0;
    while (!bus.instr_ready && n < 20) begin
      tick();
      n++;
    end
    tick();
    bus.instr_valid = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      if (bus.alu_add | bus.alu_sub | bus.alu_lshift | bus.alu_rshift) scnt++;
      mask |= {bus.alu_rshift, bus.alu_lshift, bus.alu_sub, bus.alu_add};
      if (bus.illegal) ill = 1'b1;
      if (bus.done) begin
        lat = k;
        break;
      end
      if (ill) break;
      tick();
    end
    tick();
  endtask

  task automatic test_reset;
    logic [3:0] v;
    bus.instr_valid = 1'b0;
    bus.instr       = 10'h0;
    tick();
    checks++;
    if ({bus.alu_add, bus.alu_sub, bus.alu_lshift, bus.alu_rshift, bus.done, bus.illegal} !== 6'b0) begin
      errors++;
      $display("FAIL reset_pulses: got %b want 000000",
               {bus.alu_add, bus.alu_sub, bus.alu_lshift, bus.alu_rshift, bus.done, bus.illegal});
    end
    tick();
    reset = 1'b0;
    tick();
    checks++;
    if (bus.instr_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready: got %b want 1", bus.instr_ready);
    end
    checks++;
    if ({bus.flag, bus.alu_in1, bus.alu_in2} !== 9'h0) begin
      errors++;
      $display("FAIL reset_flag_ops: got %h want 000", {bus.flag, bus.alu_in1, bus.alu_in2});
    end
    for (int r = 0; r < 4; r++) begin
      rd_reg(2'(r), v);
      checks++;
      if (v !== 4'h0) begin
        errors++;
        $display("FAIL reset_R%0d: got %h want 0", r, v);
      end
    end
  endtask

  task automatic test_add;
    int lat, sc;
    logic [3:0] m, v;
    logic il;
    exec(ldi(2'd1, 4'h9), lat, m, sc, il);
    checks++;
    if (lat !== 2) begin
      errors++;
      $display("FAIL ldi_latency: got %0d want 2", lat);
    end
    exec(ldi(2'd2, 4'h8), lat, m, sc, il);
    exec(rr(3'b000, 2'd3, 2'd1, 2'd2), lat, m, sc, il);
    checks++;
    if (lat !== 3) begin
      errors++;
      $display("FAIL add_latency: got %0d want 3", lat);
    end
    checks++;
    if (m !== 4'b0001 || sc !== 1) begin
      errors++;
      $display("FAIL add_strobe: got mask %b cycles %0d want 0001 1", m, sc);
    end
    checks++;
    if (bus.alu_in1 !== 4'h9 || bus.alu_in2 !== 4'h8) begin
      errors++;
      $display("FAIL add_operands: got %h %h want 9 8", bus.alu_in1, bus.alu_in2);
    end
    rd_reg(2'd3, v);
    checks++;
    if (v !== 4'h1) begin
      errors++;
      $display("FAIL add_R3: got %h want 1", v);
    end
    checks++;
    if (bus.flag !== 1'b1) begin
      errors++;
      $display("FAIL add_flag: got %b want 1", bus.flag);
    end
  endtask

  task automatic test_sub;
    int lat, sc;
    logic [3:0] m, v;
    logic il;
    exec(ldi(2'd0, 4'h3), lat, m, sc, il);
    checks++;
    if (bus.flag !== 1'b1) begin
      errors++;
      $display("FAIL ldi_keeps_flag: got %b want 1", bus.flag);
    end
    exec(ldi(2'd1, 4'h5), lat, m, sc, il);
    exec(rr(3'b001, 2'd2, 2'd0, 2'd1), lat, m, sc, il);
    checks++;
    if (m !== 4'b0010 || sc !== 1 || lat !== 3) begin
      errors++;
      $display("FAIL sub_strobe: got mask %b cycles %0d lat %0d want 0010 1 3", m, sc, lat);
    end
    rd_reg(2'd2, v);
    checks++;
    if (v !== 4'hE || bus.flag !== 1'b1) begin
      errors++;
      $display("FAIL sub_result: got R2=%h flag=%b want E 1", v, bus.flag);
    end
  endtask

  task automatic test_shift;
    int lat, sc;
    logic [3:0] m, v;
    logic il;
    exec(ldi(2'd0, 4'hA), lat, m, sc, il);
    exec(rr(3'b010, 2'd0, 2'd0, 2'd0), lat, m, sc, il);
    rd_reg(2'd0, v);
    checks++;
    if (m !== 4'b0100 || v !== 4'h4 || bus.flag !== 1'b1) begin
      errors++;
      $display("FAIL lsh: got mask %b R0=%h flag=%b want 0100 4 1", m, v, bus.flag);
    end
    exec(rr(3'b011, 2'd0, 2'd0, 2'd0), lat, m, sc, il);
    rd_reg(2'd0, v);
    checks++;
    if (m !== 4'b1000 || v !== 4'h2 || bus.flag !== 1'b0) begin
      errors++;
      $display("FAIL rsh: got mask %b R0=%h flag=%b want 1000 2 0", m, v, bus.flag);
    end
  endtask

  task automatic test_mov;
    int lat, sc;
    logic [3:0] m, v;
    logic il;
    exec(rr(3'b101, 2'd3, 2'd0, 2'd1), lat, m, sc, il);
    rd_reg(2'd3, v);
    checks++;
    if (v !== 4'h2 || lat !== 2 || m !== 4'b0000) begin
      errors++;
      $display("FAIL mov: got R3=%h lat %0d mask %b want 2 2 0000", v, lat, m);
    end
  endtask

  task automatic test_illegal;
    int lat, sc;
    logic [3:0] m, v0, v1, v2, v3;
    logic il;
    exec(rr(3'b110, 2'd3, 2'd0, 2'd1), lat, m, sc, il);
    checks++;
    if (il !== 1'b1 || lat !== -1 || m !== 4'b0000) begin
      errors++;
      $display("FAIL illegal_110: got ill %b lat %0d mask %b want 1 -1 0000", il, lat, m);
    end
    checks++;
    if (bus.instr_ready !== 1'b1) begin
      errors++;
      $display("FAIL illegal_ready: got %b want 1", bus.instr_ready);
    end
    exec(rr(3'b111, 2'd2, 2'd1, 2'd1), lat, m, sc, il);
    checks++;
    if (il !== 1'b1 || lat !== -1) begin
      errors++;
      $display("FAIL illegal_111: got ill %b lat %0d want 1 -1", il, lat);
    end
    rd_reg(2'd0, v0);
    rd_reg(2'd1, v1);
    rd_reg(2'd2, v2);
    rd_reg(2'd3, v3);
    checks++;
    if ({v0, v1, v2, v3, 3'b0, bus.flag} !== 20'h25E20) begin
      errors++;
      $display("FAIL illegal_state: got regs %h%h%h%h flag %b want 25E2 0", v0, v1, v2, v3, bus.flag);
    end
  endtask

  task automatic test_back_to_back;
    logic [9:0] prog [3];
    int hs, multi, dones;
    logic go;
    logic [3:0] v;
    prog[0] = ldi(2'd0, 4'hF);
    prog[1] = ldi(2'd1, 4'h2);
    prog[2] = rr(3'b000, 2'd2, 2'd0, 2'd1);
    hs = 0;
    multi = 0;
    dones = 0;
    bus.instr_valid = 1'b1;
    bus.instr       = prog[0];
    for (int c = 0; c < 30; c++) begin
      if (int'(bus.alu_add) + int'(bus.alu_sub) + int'(bus.alu_lshift) + int'(bus.alu_rshift) > 1)
        multi++;
      if (bus.done) dones++;
      go = bus.instr_valid & bus.instr_ready;
      tick();
      if (go) begin
        hs++;
        if (hs < 3) bus.instr = prog[hs];
        else bus.instr_valid = 1'b0;
      end
    end
    checks++;
    if (hs !== 3 || dones !== 3) begin
      errors++;
      $display("FAIL b2b_count: got hs %0d done %0d want 3 3", hs, dones);
    end
    checks++;
    if (multi !== 0) begin
      errors++;
      $display("FAIL b2b_strobes: got %0d multi-strobe cycles want 0", multi);
    end
    rd_reg(2'd2, v);
    checks++;
    if (v !== 4'h1 || bus.flag !== 1'b1) begin
      errors++;
      $display("FAIL b2b_result: got R2=%h flag=%b want 1 1", v, bus.flag);
    end
  endtask

  task automatic test_reset_mid;
    int dones;
    logic [3:0] v;
    bus.instr_valid = 1'b1;
    bus.instr       = rr(3'b000, 2'd3, 2'd0, 2'd1);
    tick();
    bus.instr_valid = 1'b0;
    tick();
    checks++;
    if (bus.alu_add !== 1'b1) begin
      errors++;
      $display("FAIL mid_issue: got add %b want 1", bus.alu_add);
    end
    reset = 1'b1;
    #1;
    checks++;
    if ({bus.alu_add, bus.done, bus.instr_ready} !== 3'b001) begin
      errors++;
      $display("FAIL mid_abort: got add/done/ready %b want 001",
               {bus.alu_add, bus.done, bus.instr_ready});
    end
    tick();
    reset = 1'b0;
    dones = 0;
    for (int c = 0; c < 5; c++) begin
      if (bus.done) dones++;
      tick();
    end
    rd_reg(2'd3, v);
    checks++;
    if (v !== 4'h0 || dones !== 0 || bus.instr_ready !== 1'b1) begin
      errors++;
      $display("FAIL mid_after: got R3=%h done %0d ready %b want 0 0 1", v, dones, bus.instr_ready);
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_shift();
    test_mov();
    test_illegal();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish want finish");
    $fatal(1, "timeout");
  end
endmodule
